// File: rtl/inst_rom_loadable.sv
// Loadable instruction store for the ARK fetch stage.
// A program is streamed in through the load port, then served to fetch
// with a one-cycle registered read. Fetch is only serviced in RUN, so a
// partially loaded program is never visible to the core.
module inst_rom_loadable #(
  parameter int                ADDR_W = 8,
  parameter int                INST_W = 9,
  parameter int                DEPTH  = 256,
  parameter logic [INST_W-1:0] NOP    = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              LoadStart,
  input  logic              LoadValid,
  input  logic [INST_W-1:0] LoadData,
  input  logic              LoadLast,
  output logic              LoadReady,
  output logic [ADDR_W:0]   LoadCount,
  output logic              Running,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] Address,
  input  logic              Stall,
  output logic [INST_W-1:0] Instruction,
  output logic              InstValid,
  output logic              AddrErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Counter is one bit wider than the address so a full DEPTH=2**ADDR_W load is representable.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

  state_t              state;
  logic [ADDR_W:0]     load_cnt;
  logic [ADDR_W:0]     cnt_inc;
  logic                wr_en;
  logic                in_range;
  logic [INST_W-1:0]   mem [DEPTH];

  logic [INST_W-1:0]   inst_p1;
  logic                vld_p1;
  logic                err_p1;

  // The load counter doubles as the write pointer: both restart together and advance together.
  assign cnt_inc   = load_cnt + CNT_ONE;
  assign wr_en     = (state == LOAD) && LoadValid;
  assign in_range  = ({1'b0, Address} < DEPTH_LIM);
  assign LoadCount = load_cnt;

  // Controller: sequences IDLE -> LOAD -> RUN and keeps the status flags registered with the state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      load_cnt  <= '0;
      LoadReady <= 1'b0;
      Running   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (LoadStart) begin
            state     <= LOAD;
            load_cnt  <= '0;
            LoadReady <= 1'b1;
          end
        end
        LOAD: begin
          // LoadStart is deliberately ignored here: no restart mid-load.
          if (LoadValid) begin
            load_cnt <= cnt_inc;
            if (LoadLast || (cnt_inc == DEPTH_LIM)) begin
              state     <= RUN;
              LoadReady <= 1'b0;
              Running   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (LoadStart) begin
            state     <= LOAD;
            load_cnt  <= '0;
            LoadReady <= 1'b1;
            Running   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          LoadReady <= 1'b0;
          Running   <= 1'b0;
        end
      endcase
    end
  end

  // Program store write port; contents survive reset and are not auto-filled.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[load_cnt[ADDR_W-1:0]] <= LoadData;
    end
  end

  // ---- stage p0 -> p1: registered fetch read, held while stalled ----
  always_ff @(posedge CLK) begin
    if (Reset) begin
      inst_p1 <= NOP;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
    end else if ((state != RUN) || LoadStart) begin
      inst_p1 <= NOP;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
    end else if (!Stall) begin
      if (FetchReq) begin
        inst_p1 <= in_range ? mem[Address] : NOP;
        vld_p1  <= 1'b1;
        err_p1  <= !in_range;
      end else begin
        inst_p1 <= NOP;
        vld_p1  <= 1'b0;
        err_p1  <= 1'b0;
      end
    end
  end

  assign Instruction = inst_p1;
  assign InstValid   = vld_p1;
  assign AddrErr     = err_p1;

endmodule

// File: tb/tb_inst_rom_loadable.sv
// Bench for inst_rom_loadable: two instances (DEPTH=200 and DEPTH=256) share
// one stimulus stream; a behavioural model tracks each one.
module tb_inst_rom_loadable;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       Reset, LoadStart, LoadValid, LoadLast, FetchReq, Stall;
  logic [8:0] LoadData;
  logic [7:0] Address;

  logic       a_ready, a_running, a_vld, a_err;
  logic [8:0] a_count, a_inst;
  logic       b_ready, b_running, b_vld, b_err;
  logic [8:0] b_count, b_inst;

  inst_rom_loadable #(.ADDR_W(8), .INST_W(9), .DEPTH(200), .NOP(9'h000)) dut_a (
    .CLK(CLK), .Reset(Reset), .LoadStart(LoadStart), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadLast(LoadLast), .LoadReady(a_ready), .LoadCount(a_count),
    .Running(a_running), .FetchReq(FetchReq), .Address(Address), .Stall(Stall),
    .Instruction(a_inst), .InstValid(a_vld), .AddrErr(a_err)
  );

  inst_rom_loadable #(.ADDR_W(8), .INST_W(9), .DEPTH(256), .NOP(9'h000)) dut_b (
    .CLK(CLK), .Reset(Reset), .LoadStart(LoadStart), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadLast(LoadLast), .LoadReady(b_ready), .LoadCount(b_count),
    .Running(b_running), .FetchReq(FetchReq), .Address(Address), .Stall(Stall),
    .Instruction(b_inst), .InstValid(b_vld), .AddrErr(b_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 loading, 2 serving fetches.
  int         m_depth [2] = '{200, 256};
  logic [8:0] m_mem   [2][256];
  bit         m_known [2][256];
  int         m_mode  [2];
  int         m_cnt   [2];
  logic [8:0] m_inst  [2];
  bit         m_vld   [2];
  bit         m_err   [2];
  bit         m_ik    [2];

  logic [8:0] prog [4] = '{9'h101, 9'h0A2, 9'h1FF, 9'h033};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_out(input int i);
    m_inst[i] = 9'h000; m_vld[i] = 0; m_err[i] = 0; m_ik[i] = 1;
  endtask

  task automatic begin_load(input int i);
    m_mode[i] = 1; m_cnt[i] = 0;
    for (int a = 0; a < 256; a++) m_known[i][a] = 0;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        m_mode[i] = 0; m_cnt[i] = 0; clr_out(i);
      end else if (m_mode[i] == 0) begin
        clr_out(i);
        if (LoadStart) begin_load(i);
      end else if (m_mode[i] == 1) begin
        clr_out(i);
        if (LoadValid) begin
          m_mem[i][m_cnt[i]] = LoadData;
          m_known[i][m_cnt[i]] = 1;
          m_cnt[i]++;
          if (LoadLast || m_cnt[i] == m_depth[i]) m_mode[i] = 2;
        end
      end else begin
        if (LoadStart) begin
          begin_load(i); clr_out(i);
        end else if (!Stall) begin
          if (FetchReq) begin
            m_vld[i] = 1;
            if (int'(Address) < m_depth[i]) begin
              m_err[i] = 0; m_inst[i] = m_mem[i][Address]; m_ik[i] = m_known[i][Address];
            end else begin
              m_err[i] = 1; m_inst[i] = 9'h000; m_ik[i] = 1;
            end
          end else begin
            clr_out(i);
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      string s;
      s = {tag, (i == 0) ? "_d200" : "_d256"};
      chk({s, "_vld"},   (i == 0) ? 16'(a_vld)     : 16'(b_vld),     16'(m_vld[i]));
      chk({s, "_err"},   (i == 0) ? 16'(a_err)     : 16'(b_err),     16'(m_err[i]));
      chk({s, "_ready"}, (i == 0) ? 16'(a_ready)   : 16'(b_ready),   16'(m_mode[i] == 1));
      chk({s, "_run"},   (i == 0) ? 16'(a_running) : 16'(b_running), 16'(m_mode[i] == 2));
      chk({s, "_count"}, (i == 0) ? 16'(a_count)   : 16'(b_count),   16'(m_cnt[i]));
      if (m_ik[i])
        chk({s, "_inst"}, (i == 0) ? 16'(a_inst) : 16'(b_inst), 16'(m_inst[i]));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    int written;
    Reset = 1; LoadStart = 0; LoadValid = 0; LoadLast = 0; LoadData = '0;
    FetchReq = 0; Address = '0; Stall = 0;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_cnt[i] = 0; clr_out(i);
      for (int a = 0; a < 256; a++) begin m_known[i][a] = 0; m_mem[i][a] = '0; end
    end

    // Power-on reset, then fetch requests in IDLE must be ignored.
    tick("rst0"); tick("rst1");
    Reset = 0; FetchReq = 1; Address = 8'd0;
    tick("idle_fetch"); tick("idle_fetch");

    // Four-word program with LoadLast on the final word; fetch requests held during load.
    LoadStart = 1; tick("load_start");
    LoadStart = 0;
    for (int k = 0; k < 4; k++) begin
      LoadValid = 1; LoadData = prog[k]; LoadLast = (k == 3);
      tick("load4");
    end
    chk("load4_count", 16'(b_count), 16'd4);
    chk("load4_running", 16'(b_running), 16'd1);
    LoadValid = 0; LoadLast = 0;

    // Back-to-back fetch of addresses 0..3.
    for (int k = 0; k < 4; k++) begin
      Address = 8'(k); tick("fetch_seq");
      chk("fetch_seq_inst", 16'(a_inst), 16'(prog[k]));
    end

    // Out-of-range on the DEPTH=200 instance, then a normal fetch.
    Address = 8'd210; tick("oor");
    chk("oor_err", 16'(a_err), 16'd1);
    chk("oor_inst", 16'(a_inst), 16'h000);
    Address = 8'd1; tick("after_oor");
    chk("after_oor_inst", 16'(a_inst), 16'h0A2);
    chk("after_oor_err", 16'(a_err), 16'd0);

    // Stall holds the registered result while FetchReq toggles.
    Address = 8'd2; tick("pre_stall");
    Stall = 1;
    for (int k = 0; k < 3; k++) begin
      FetchReq = (k % 2 == 0) ? 1'b0 : 1'b1;
      Address = 8'($urandom_range(0, 3));
      tick("stall");
      chk("stall_hold", 16'(b_inst), 16'h1FF);
    end
    Stall = 0;

    // Random fetch traffic.
    for (int k = 0; k < 60; k++) begin
      FetchReq = ($urandom_range(0, 3) != 0);
      Stall = ($urandom_range(0, 4) == 0);
      Address = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      tick("rand_fetch4");
    end
    Stall = 0;

    // Reset held two cycles in RUN.
    Reset = 1; FetchReq = 1; tick("rst_run"); tick("rst_run");
    chk("rst_run_inst", 16'(a_inst), 16'h000);
    chk("rst_run_running", 16'(b_running), 16'd0);
    Reset = 0; FetchReq = 0;

    // Partial load aborted by reset; fetch stays ignored afterwards.
    LoadStart = 1; tick("load_abort_start");
    LoadStart = 0;
    for (int k = 0; k < 100; k++) begin
      LoadValid = 1; LoadData = 9'($urandom); tick("load_partial");
    end
    Reset = 1; LoadValid = 0; tick("abort");
    Reset = 0; FetchReq = 1; Address = 8'd5;
    for (int k = 0; k < 3; k++) tick("after_abort");
    chk("after_abort_vld", 16'(b_vld), 16'd0);
    FetchReq = 0;

    // Full load with gaps and no LoadLast; stray LoadStart while loading is ignored.
    LoadStart = 1; tick("full_start");
    LoadStart = 0;
    written = 0;
    for (int k = 0; k < 2000 && m_mode[1] != 2; k++) begin
      LoadValid = ($urandom_range(0, 3) != 0);
      LoadData = 9'($urandom);
      LoadStart = (written < 190) && ($urandom_range(0, 15) == 0);
      if (LoadValid) written++;
      tick("full_load");
    end
    LoadValid = 0; LoadStart = 0;
    chk("full_count_d256", 16'(b_count), 16'h100);
    chk("full_count_d200", 16'(a_count), 16'd200);
    chk("full_running", 16'(b_running), 16'd1);

    // Random fetch across the full address range.
    for (int k = 0; k < 200; k++) begin
      FetchReq = ($urandom_range(0, 3) != 0);
      Stall = ($urandom_range(0, 5) == 0);
      Address = 8'($urandom_range(0, 255));
      tick("rand_fetch_full");
    end
    Stall = 0; FetchReq = 1;

    // Reload request from RUN clears the output valid.
    LoadStart = 1; tick("reload");
    chk("reload_ready", 16'(b_ready), 16'd1);
    LoadStart = 0; FetchReq = 0;
    tick("reload_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
